// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the shared memory.
interface imem_dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    // Load/store requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    // Shared single-port memory
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_enable;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_enable, mem_wr
    );

    // Requester/memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_enable, mem_wr
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and
// load/store. One transaction at a time: IDLE -> ACCESS (MEM_LAT cycles) -> DONE (ack).
module imem_dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic                clk,
    input  logic                rst,
    imem_dmem_arbiter_if.slave  bus,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        r_state;
    logic          r_last_d;   // 1: last grant went to the data port
    logic          r_win_d;    // 1: current transaction belongs to the data port
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_we;
    logic [3:0]    r_cnt;
    logic [DW-1:0] r_resp;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic          r_if_ack;
    logic          r_d_ack;

    logic          w_any_req;
    logic          w_grant_d;

    // Pick the winner: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        w_any_req = bus.if_req | bus.d_req;
        w_grant_d = bus.d_req & (~bus.if_req | ~r_last_d);
    end

    // Transaction FSM; all memory-side and ack outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_last_d <= 1'b1;
            r_win_d  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_resp   <= '0;
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_state  <= StAccess;
                        r_win_d  <= w_grant_d;
                        r_last_d <= w_grant_d;
                        r_addr   <= w_grant_d ? bus.d_addr : bus.if_addr;
                        r_wdata  <= w_grant_d ? bus.d_wdata : '0;
                        r_we     <= w_grant_d & bus.d_we;
                        r_cnt    <= 4'(MEM_LAT);
                        r_mem_en <= 1'b1;
                        r_mem_wr <= w_grant_d & bus.d_we;
                    end
                end
                StAccess: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Last enabled cycle: sample the memory and hand off to DONE.
                    if (r_cnt == 4'd1) begin
                        r_resp   <= r_we ? '0 : bus.mem_rdata;
                        r_mem_en <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_if_ack <= ~r_win_d;
                        r_d_ack  <= r_win_d;
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_state  <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Output mapping; no path from the request inputs reaches these.
    always_comb begin
        bus.mem_addr   = r_addr;
        bus.mem_wdata  = r_wdata;
        bus.mem_enable = r_mem_en;
        bus.mem_wr     = r_mem_wr;
        bus.if_ack     = r_if_ack;
        bus.d_ack      = r_d_ack;
        bus.if_rdata   = r_resp;
        bus.d_rdata    = r_resp;
        busy           = (r_state != StIdle);
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3),
// behavioural memories, and per-port scoreboards of expected ack data.
module tb_imem_dmem_arbiter;

    logic clk;
    logic rst;
    logic busy1;
    logic busy3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_if1[$];
    logic [31:0] q_d1[$];
    logic [31:0] q_if3[$];
    logic [31:0] q_d3[$];

    logic [31:0] mem1[0:255];
    logic [31:0] mem3[0:255];

    imem_dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    imem_dmem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    imem_dmem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1),
        .busy (busy1)
    );

    imem_dmem_arbiter #(.MEM_LAT(3), .AW(32), .DW(32)) u_dut3 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus3),
        .busy (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial memory contents: word 4 (byte 0x10) holds an instruction, others a pattern.
    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(i));
    endfunction

    assign bus1.mem_rdata = mem1[bus1.mem_addr[9:2]];
    assign bus3.mem_rdata = mem3[bus3.mem_addr[9:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
        end else if (bus1.mem_enable && bus1.mem_wr) begin
            mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
        end else if (bus3.mem_enable && bus3.mem_wr) begin
            mem3[bus3.mem_addr[9:2]] <= bus3.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ack monitor: every ack must match the oldest expected response for its port.
    always @(negedge clk) begin
        if (bus1.if_ack) begin
            check("if1_ack_queued", 64'(q_if1.size() != 0), 1);
            if (q_if1.size() != 0) check("if1_rdata", bus1.if_rdata, q_if1.pop_front());
        end
        if (bus1.d_ack) begin
            check("d1_ack_queued", 64'(q_d1.size() != 0), 1);
            if (q_d1.size() != 0) check("d1_rdata", bus1.d_rdata, q_d1.pop_front());
        end
        if (bus3.if_ack) begin
            check("if3_ack_queued", 64'(q_if3.size() != 0), 1);
            if (q_if3.size() != 0) check("if3_rdata", bus3.if_rdata, q_if3.pop_front());
        end
        if (bus3.d_ack) begin
            check("d3_ack_queued", 64'(q_d3.size() != 0), 1);
            if (q_d3.size() != 0) check("d3_rdata", bus3.d_rdata, q_d3.pop_front());
        end
        if (busy1 || busy3) begin
            check("acks_exclusive", {bus1.if_ack & bus1.d_ack, bus3.if_ack & bus3.d_ack}, 0);
            check("wr_implies_en", {bus1.mem_wr & ~bus1.mem_enable,
                                    bus3.mem_wr & ~bus3.mem_enable}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0;   bus1.d_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_addr = '0;   bus3.d_wdata = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy",   {busy1, busy3}, 0);
        check("rst_en",     {bus1.mem_enable, bus3.mem_enable, bus1.mem_wr, bus3.mem_wr}, 0);
        check("rst_acks",   {bus1.if_ack, bus1.d_ack, bus3.if_ack, bus3.d_ack}, 0);
        check("rst_addr",   bus1.mem_addr, 0);
        check("rst_rdata",  bus1.if_rdata, 0);
        rst = 1'b1;
        tick();

        // Lone fetch, MEM_LAT=1
        bus1.if_req = 1'b1; bus1.if_addr = 32'h10;
        q_if1.push_back(32'h0050_0093);
        tick();
        check("f_en",   bus1.mem_enable, 1);
        check("f_addr", bus1.mem_addr, 32'h10);
        check("f_wr",   bus1.mem_wr, 0);
        check("f_busy", busy1, 1);
        tick();
        check("f_ack",  bus1.if_ack, 1);
        check("f_en_done", bus1.mem_enable, 0);
        bus1.if_req = 1'b0;
        tick();
        check("f_idle", {busy1, bus1.if_ack}, 0);

        // Lone store then load back, MEM_LAT=1
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h200; bus1.d_wdata = 32'hDEAD_BEEF;
        q_d1.push_back(32'h0);
        tick();
        check("st_en_wr", {bus1.mem_enable, bus1.mem_wr}, 2'b11);
        check("st_addr",  bus1.mem_addr, 32'h200);
        check("st_wdata", bus1.mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("st_ack",   bus1.d_ack, 1);
        bus1.d_req = 1'b0;
        tick();
        bus1.d_req = 1'b1; bus1.d_we = 1'b0;
        q_d1.push_back(32'hDEAD_BEEF);
        tick();
        check("ld_wr",    bus1.mem_wr, 0);
        tick();
        check("ld_ack",   bus1.d_ack, 1);
        bus1.d_req = 1'b0;
        tick();

        // Both requesting continuously: fetch, data, fetch, data
        bus1.if_req = 1'b1; bus1.if_addr = 32'h10;
        bus1.d_req  = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h40;
        q_if1.push_back(32'h0050_0093); q_if1.push_back(32'h0050_0093);
        q_d1.push_back(32'hC0DE_0010);  q_d1.push_back(32'hC0DE_0010);
        for (int t = 0; t < 4; t++) begin
            tick();
            check("rr_grant_addr", bus1.mem_addr, (t % 2 == 0) ? 32'h10 : 32'h40);
            tick();
            check("rr_acks", {bus1.if_ack, bus1.d_ack}, (t % 2 == 0) ? 2'b10 : 2'b01);
            if (t == 3) begin
                bus1.if_req = 1'b0;
                bus1.d_req  = 1'b0;
            end
            tick();
        end
        check("rr_idle", busy1, 0);

        // MEM_LAT=3 load with address changed after grant
        bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h40;
        q_d3.push_back(32'hC0DE_0010);
        tick();
        check("l3_addr1", {bus3.mem_enable, bus3.mem_addr}, {1'b1, 32'h40});
        bus3.d_addr = 32'h44;
        tick();
        check("l3_addr2", {bus3.mem_enable, bus3.mem_addr}, {1'b1, 32'h40});
        tick();
        check("l3_addr3", {bus3.mem_enable, bus3.mem_addr}, {1'b1, 32'h40});
        check("l3_noack", bus3.d_ack, 0);
        tick();
        check("l3_ack", {bus3.d_ack, bus3.mem_enable}, 2'b10);
        bus3.d_req = 1'b0;
        tick();

        // Fetch request pulsed for a single cycle still completes, exactly once
        bus1.if_req = 1'b1; bus1.if_addr = 32'h44;
        q_if1.push_back(32'hC0DE_0011);
        tick();
        bus1.if_req = 1'b0;
        bus1.if_addr = 32'h0;
        check("drop_en", bus1.mem_enable, 1);
        tick();
        check("drop_ack", bus1.if_ack, 1);
        tick();
        check("drop_idle", busy1, 0);
        tick();
        check("drop_no_restart", {busy1, bus1.mem_enable}, 0);

        // Reset during the second ACCESS cycle of a MEM_LAT=3 store
        bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 32'h80; bus3.d_wdata = 32'h1234_5678;
        tick();
        check("rs_wr", {bus3.mem_enable, bus3.mem_wr}, 2'b11);
        tick();
        #2 rst = 1'b0;
        #1;
        check("rs_drop", {bus3.mem_enable, bus3.mem_wr, busy3}, 0);
        bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("rs_quiet", {busy3, bus3.d_ack, bus3.if_ack}, 0);

        // After reset fetch wins the tie, then data, each served normally
        bus3.if_req = 1'b1; bus3.if_addr = 32'h10;
        bus3.d_req  = 1'b1; bus3.d_addr  = 32'h40;
        q_if3.push_back(32'h0050_0093);
        q_d3.push_back(32'hC0DE_0010);
        for (int t = 0; t < 2; t++) begin
            tick();
            check("rs_grant_addr", bus3.mem_addr, (t == 0) ? 32'h10 : 32'h40);
            tick();
            tick();
            tick();
            check("rs_acks", {bus3.if_ack, bus3.d_ack}, (t == 0) ? 2'b10 : 2'b01);
            if (t == 1) begin
                bus3.if_req = 1'b0;
                bus3.d_req  = 1'b0;
            end
            tick();
        end
        tick();

        // Every expected response must have been acknowledged
        check("sb_empty", {q_if1.size(), q_d1.size(), q_if3.size(), q_d3.size()}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the load/store requester of a multi-cycle core variant.
- Arbitrates between them with round-robin fairness and runs exactly one memory transaction at a time.
- Drives the memory's addr, data_in, enable and wr ports, then returns read data to the requester with a one-cycle acknowledge.
- Sits between the PC/fetch logic and load/store logic on one side, and the shared memory on the other.

Parameters:
- MEM_LAT, 1: cycles the memory is held enabled per transaction (legal range 1..15); read data is sampled on the last of these cycles.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse, fetch complete.
- if_rdata  out  DW  fetched instruction, valid while if_ack=1.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_ack  out  1  one-cycle pulse, data access complete.
- d_rdata  out  DW  load data, valid while d_ack=1; 0 for stores.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_enable  out  1  memory enable.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all outputs go to 0; the latched address, write data and response data go to 0.
  - last_grant is set to DATA, so fetch wins the first tie.
  - Reset asserted mid-transaction abandons it; no ack is produced for it.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch the granted address, the write data (data port only) and the we bit (fetch forces we=0); record the winner; update last_grant; load cnt=MEM_LAT; go to ACCESS.
- ACCESS:
  - Outputs: mem_enable=1; mem_addr and mem_wdata come from the latched registers; mem_wr=latched we on every ACCESS cycle (repeated writes of the same data are harmless).
  - cnt decrements each cycle.
  - When cnt==1: capture mem_rdata into the response register (store captures 0 instead), then go to DONE.
- DONE:
  - Assert the winner's ack for exactly one cycle, with the response on its rdata port.
  - mem_enable=0 and mem_wr=0.
  - Next state is IDLE unconditionally.
- Outputs are registered or state-decoded; there is no combinational path from if_req or d_req to any mem_* output.
- Latency: a request sampled in IDLE at edge k produces ack during cycle k+MEM_LAT+1. A lone requester therefore sees a throughput of one transaction per MEM_LAT+2 cycles.
- Requesters must hold req and the request fields stable until ack.
  - Field changes after grant are ignored, because the values are latched.
  - Dropping req mid-transaction does not cancel it; the ack is still issued.
- After its ack, a requester that still holds req in the following IDLE cycle is treated as making a new request. Back-to-back fetches are done by updating the address on the ack edge.
- Fairness: with both requesters continuously asserting, grants strictly alternate. No requester waits more than one foreign transaction.
- if_ack and d_ack are never high in the same cycle.
- mem_wr is never 1 while mem_enable is 0.
- Non-idle outputs are never X.

Test Plan:
- Reset then a lone fetch: MEM_LAT=1, if_req=1, if_addr=0x10, memory word 0x00500093 -> mem_enable=1 with mem_addr=0x10 for one cycle; if_ack=1 with if_rdata=0x00500093 two cycles after grant; busy drops the next cycle.
- Lone store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_wr=1 and mem_enable=1 for MEM_LAT cycles; d_ack pulses with d_rdata=0; a following load at 0x200 returns 0xDEADBEEF.
- Simultaneous requests right after reset: if_req=d_req=1 held -> grant order is fetch, data, fetch, data; ack pulses alternate with no overlap.
- MEM_LAT=3 with a load at 0x40 and a mid-access address change to 0x44 -> mem_addr stays 0x40 for 3 cycles; d_ack arrives at cycle 4 after grant with data from 0x40.
- Request drop: if_req is pulsed for 1 cycle only -> the transaction still completes and if_ack pulses once; no second transaction starts.
- Reset mid-ACCESS: rst=0 during cycle 2 of a MEM_LAT=3 store -> mem_enable and mem_wr fall immediately; no ack; state is IDLE after release; the next request is served normally.
